mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers, one bit per cycle.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU keep their timing but return zero.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateType;

    stateType    stateReg, stateNext;
    logic [5:0]  cntReg;
    logic [63:0] accReg, accNext, result, product, mulNext;
    logic [32:0] mulSum;
    logic [31:0] operandReg, hiReg, loReg;
    logic [31:0] aMag, bMag;
    logic        isDivReg, negResultReg;
    logic        accept, isSigned, aNeg, bNeg;
`ifdef MDU_DIV_EN
    logic        negRemReg, divZeroReg, divOk;
    logic [32:0] divShift;
    logic [33:0] divDiff;
    logic [63:0] divNext;
    logic [31:0] quotient, remainder;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = RUN;
            RUN:     if (cntReg == 6'd31) stateNext = FIX;
            FIX:     stateNext = DONE;
            DONE:    stateNext = start ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy = (stateReg == RUN) || (stateReg == FIX);
        done = (stateReg == DONE);
    end

    // Operands are captured as magnitudes; signs are folded back in during FIX.
    always_comb begin
        isSigned = ~op[0];
        aNeg     = isSigned & a[31];
        bNeg     = isSigned & b[31];
        aMag     = aNeg ? 32'd0 - a : a;
        bMag     = bNeg ? 32'd0 - b : b;
        accept   = start && ((stateReg == IDLE) || (stateReg == DONE));
    end

    // Multiply: accReg holds {partial product, remaining multiplier bits}.
    always_comb begin
        mulSum  = {1'b0, accReg[63:32]} + (accReg[0] ? {1'b0, operandReg} : 33'd0);
        mulNext = {mulSum, accReg[31:1]};
`ifdef MDU_DIV_EN
        // Divide: accReg holds {remainder, dividend/quotient}. The remainder stays
        // below the divisor, so a non-negative difference never sets bit 32.
        divShift = {accReg[63:32], accReg[31]};
        divDiff  = {1'b0, divShift} - {2'b00, operandReg};
        divOk    = ~|divDiff[33:32];
        divNext  = {(divOk ? divDiff[31:0] : divShift[31:0]), accReg[30:0], divOk};
        accNext  = isDivReg ? divNext : mulNext;
`else
        accNext  = mulNext;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cntReg       <= 6'd0;
            accReg       <= 64'd0;
            operandReg   <= 32'd0;
            isDivReg     <= 1'b0;
            negResultReg <= 1'b0;
`ifdef MDU_DIV_EN
            negRemReg    <= 1'b0;
            divZeroReg   <= 1'b0;
`endif
        end else if (accept) begin
            cntReg       <= 6'd0;
            isDivReg     <= op[1];
            negResultReg <= aNeg ^ bNeg;
            operandReg   <= op[1] ? bMag : aMag;
            accReg       <= op[1] ? {32'd0, aMag} : {32'd0, bMag};
`ifdef MDU_DIV_EN
            negRemReg    <= aNeg;
            divZeroReg   <= op[1] && (b == 32'd0);
`endif
        end else if (stateReg == RUN) begin
            cntReg <= cntReg + 6'd1;
            accReg <= accNext;
        end
    end

    // With a zero divisor the remainder ends up as |a|, so the dividend-sign
    // fix restores the original a; only the quotient needs overriding.
    always_comb begin
        product = negResultReg ? 64'd0 - accReg : accReg;
`ifdef MDU_DIV_EN
        quotient  = divZeroReg ? 32'hFFFF_FFFF
                  : (negResultReg ? 32'd0 - accReg[31:0] : accReg[31:0]);
        remainder = negRemReg ? 32'd0 - accReg[63:32] : accReg[63:32];
        result    = isDivReg ? {remainder, quotient} : product;
`else
        result    = isDivReg ? 64'd0 : product;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hiReg <= 32'd0;
            loReg <= 32'd0;
        end else if (stateReg == FIX) begin
            hiReg <= result[63:32];
            loReg <= result[31:0];
        end else if (!busy) begin
            if (wr_hi) hiReg <= wdata;
            if (wr_lo) loReg <= wdata;
        end
    end

    assign hi = hiReg;
    assign lo = loReg;
endmodule
